// File: rtl/btn_serial_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btn_deser_pkg
// Purpose  : Shared types and helpers for the push-button serial deserializer.
//            - state_t : FSM state encoding (IDLE / COLLECT)
//            - cnt_w() : width of the bit counter for a given word width
// Revision : 1.0 - initial release
// ============================================================================
package btn_deser_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // Counter must be able to hold values 0..WIDTH.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : btn_deser_pkg
`default_nettype wire

// File: rtl/btn_serial_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : btn_serial_deserializer_if
// Purpose  : Output-side bundle of the button deserializer.
//   data_out  [WIDTH]  last completed word
//   out_valid          data_out holds an unconsumed word
//   out_ready          consumer accepts data_out
//   word_done          one-cycle pulse per completed word
//   bit_count [CW]     bits keyed into the current partial word
//   busy               deserializer is collecting a word
//   overrun            sticky: a completed word was dropped
//   Modports: master = deserializer side, slave = consumer side.
// Revision : 1.0 - initial release
// ============================================================================
interface btn_serial_deserializer_if #(
  parameter int WIDTH = 4
);
  import btn_deser_pkg::*;

  localparam int CW = cnt_w(WIDTH);

  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             word_done;
  logic [CW-1:0]    bit_count;
  logic             busy;
  logic             overrun;

  modport master (
    output data_out, out_valid, word_done, bit_count, busy, overrun,
    input  out_ready
  );

  modport slave (
    input  data_out, out_valid, word_done, bit_count, busy, overrun,
    output out_ready
  );

endinterface : btn_serial_deserializer_if
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync_edge
// Purpose  : Synchronises an asynchronous button level into clk and emits a
//            one-cycle pulse on the chosen transition of the synced level.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous button level
//   pulse      : one-cycle press event
//   POLARITY   : 1 = rising edge is a press, 0 = falling edge is a press
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit POLARITY    = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic din,
  output logic      pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= synced;
    end
  end

  // Flops clear to 0, so the idle-high start line rising out of reset is a
  // 0->1 transition and never looks like a falling-edge press.
  generate
    if (POLARITY) begin : g_rise
      assign pulse = synced & ~prev_q;
    end else begin : g_fall
      assign pulse = ~synced & prev_q;
    end
  endgenerate

endmodule : btn_sync_edge
`default_nettype wire

// File: rtl/btn_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : btn_serial_deserializer
// Purpose  : Collects a WIDTH-bit word keyed one bit per press on two buttons
//            ("one"/"zero") after an active-low start press, and offers it to
//            a consumer through a valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_n           : start button (active low, asynchronous)
//   btn_one, btn_zero : bit entry buttons (active high, asynchronous)
//   bus (master)      : data_out/out_valid/out_ready/word_done/bit_count/
//                       busy/overrun
// Revision : 1.0 - initial release
// ============================================================================
module btn_serial_deserializer
  import btn_deser_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit CONTINUOUS  = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  start_n,
  input  wire logic                  btn_one,
  input  wire logic                  btn_zero,
  btn_serial_deserializer_if.master  bus
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic ev_start, ev_one, ev_zero;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .POLARITY(1'b0)) u_sync_start (
    .clk(clk), .rst_n(rst_n), .din(start_n), .pulse(ev_start)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .POLARITY(1'b1)) u_sync_one (
    .clk(clk), .rst_n(rst_n), .din(btn_one), .pulse(ev_one)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .POLARITY(1'b1)) u_sync_zero (
    .clk(clk), .rst_n(rst_n), .din(btn_zero), .pulse(ev_zero)
  );

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             done_q, done_d;
  logic             bit_ev;

  // Simultaneous one/zero events are ambiguous and dropped; ev_one is the bit.
  assign bit_ev = ev_one ^ ev_zero;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {sr_q[WIDTH-2:0], ev_one};
    end else begin : g_lsb_first
      assign shifted = {ev_one, sr_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;

    // Handshake; a completion below may set valid again at the same edge.
    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (ev_start) begin
          state_d = COLLECT;
          sr_d    = '0;
          cnt_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      COLLECT: begin
        // Start has priority: a restart discards any bit event this cycle.
        if (ev_start) begin
          sr_d  = '0;
          cnt_d = '0;
        end else if (bit_ev) begin
          if (cnt_q == LAST) begin
            sr_d   = '0;
            cnt_d  = '0;
            done_d = 1'b1;
            if (!valid_q || bus.out_ready) begin
              data_d  = shifted;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
            if (!CONTINUOUS) begin
              state_d = IDLE;
            end
          end else begin
            sr_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.word_done = done_q;
  assign bus.bit_count = cnt_q;
  assign bus.busy      = (state_q == COLLECT);
  assign bus.overrun   = ovr_q;

endmodule : btn_serial_deserializer
`default_nettype wire

// File: tb/tb_btn_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_serial_deserializer
// Purpose  : Self-checking bench. Three deserializers share the button inputs:
//            a: MSB first, single word   b: LSB first, single word
//            c: MSB first, continuous
//            Expected completed words are queued per instance and checked by
//            monitors on every word_done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_serial_deserializer;

  typedef struct {
    logic [3:0] data;
    logic       valid;
    logic       ovr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, start_n, btn_one, btn_zero;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q_a[$], q_b[$], q_c[$];

  always #5 clk = ~clk;

  btn_serial_deserializer_if #(.WIDTH(4)) bus_a ();
  btn_serial_deserializer_if #(.WIDTH(4)) bus_b ();
  btn_serial_deserializer_if #(.WIDTH(4)) bus_c ();

  btn_serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1), .CONTINUOUS(1'b0), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_n(start_n), .btn_one(btn_one), .btn_zero(btn_zero),
    .bus(bus_a.master));
  btn_serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b0), .CONTINUOUS(1'b0), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_n(start_n), .btn_one(btn_one), .btn_zero(btn_zero),
    .bus(bus_b.master));
  btn_serial_deserializer #(.WIDTH(4), .MSB_FIRST(1'b1), .CONTINUOUS(1'b1), .SYNC_STAGES(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .start_n(start_n), .btn_one(btn_one), .btn_zero(btn_zero),
    .bus(bus_c.master));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_n = 1'b0; tick(5);
    start_n = 1'b1; tick(5);
  endtask

  task automatic press_bit(input logic b);
    if (b) btn_one = 1'b1; else btn_zero = 1'b1;
    tick(5);
    btn_one = 1'b0; btn_zero = 1'b0;
    tick(5);
  endtask

  task automatic key4(input logic [3:0] bits);
    for (int i = 3; i >= 0; i--) press_bit(bits[i]);
  endtask

  task automatic set_ready(input logic r);
    bus_a.out_ready = r; bus_b.out_ready = r; bus_c.out_ready = r;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && bus_a.word_done) begin
      if (q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_word: unexpected word_done data=%0h", bus_a.data_out);
      end else begin
        e = q_a.pop_front();
        chk("a_data", bus_a.data_out, e.data);
        chk("a_valid", bus_a.out_valid, e.valid);
        chk("a_overrun", bus_a.overrun, e.ovr);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && bus_b.word_done) begin
      if (q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_word: unexpected word_done data=%0h", bus_b.data_out);
      end else begin
        e = q_b.pop_front();
        chk("b_data", bus_b.data_out, e.data);
        chk("b_valid", bus_b.out_valid, e.valid);
        chk("b_overrun", bus_b.overrun, e.ovr);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (rst_n && bus_c.word_done) begin
      if (q_c.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL c_word: unexpected word_done data=%0h", bus_c.data_out);
      end else begin
        e = q_c.pop_front();
        chk("c_data", bus_c.data_out, e.data);
        chk("c_valid", bus_c.out_valid, e.valid);
        chk("c_overrun", bus_c.overrun, e.ovr);
      end
    end
  end

  task automatic chk_idle_all(input string tag);
    @(negedge clk);
    chk({tag, "_a_data"},  bus_a.data_out, 0);  chk({tag, "_b_data"},  bus_b.data_out, 0);
    chk({tag, "_c_data"},  bus_c.data_out, 0);
    chk({tag, "_a_valid"}, bus_a.out_valid, 0); chk({tag, "_c_valid"}, bus_c.out_valid, 0);
    chk({tag, "_a_cnt"},   bus_a.bit_count, 0); chk({tag, "_c_cnt"},   bus_c.bit_count, 0);
    chk({tag, "_a_busy"},  bus_a.busy, 0);      chk({tag, "_c_busy"},  bus_c.busy, 0);
    chk({tag, "_c_ovr"},   bus_c.overrun, 0);   chk({tag, "_a_done"},  bus_a.word_done, 0);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b0; start_n = 1'b1; btn_one = 1'b0; btn_zero = 1'b0;
    set_ready(1'b0);
    chk_idle_all("reset");
    tick(3);
    rst_n = 1'b1;
    tick(3);

    // Word 1: 1,0,1,1 -> a=1011, b=1101 (LSB first), c=1011 stays collecting
    press_start();
    @(negedge clk); chk("start_a_busy", bus_a.busy, 1); chk("start_c_busy", bus_c.busy, 1);
    q_a.push_back('{4'b1011, 1'b1, 1'b0});
    q_b.push_back('{4'b1101, 1'b1, 1'b0});
    q_c.push_back('{4'b1011, 1'b1, 1'b0});
    key4(4'b1011);
    @(negedge clk);
    chk("w1_a_busy", bus_a.busy, 0); chk("w1_a_cnt", bus_a.bit_count, 0);
    chk("w1_b_busy", bus_b.busy, 0); chk("w1_c_busy", bus_c.busy, 1);

    // Word 2 with ready low: a/b ignore bits in IDLE, c drops and flags overrun
    q_c.push_back('{4'b1011, 1'b1, 1'b1});
    key4(4'b0000);
    @(negedge clk);
    chk("w2_a_cnt", bus_a.bit_count, 0); chk("w2_b_cnt", bus_b.bit_count, 0);
    chk("w2_c_ovr", bus_c.overrun, 1);

    // One-cycle ready pulse consumes the held words; overrun is sticky
    set_ready(1'b1); tick(1); set_ready(1'b0);
    @(negedge clk);
    chk("hs_a_valid", bus_a.out_valid, 0); chk("hs_b_valid", bus_b.out_valid, 0);
    chk("hs_c_valid", bus_c.out_valid, 0); chk("hs_c_ovr", bus_c.overrun, 1);
    chk("hs_a_data", bus_a.data_out, 4'b1011);

    // Start: a/b leave IDLE, c restarts in place with overrun kept
    press_start();
    @(negedge clk);
    chk("rs_a_busy", bus_a.busy, 1); chk("rs_c_ovr", bus_c.overrun, 1);

    // Held button gives one bit; simultaneous one+zero gives none
    btn_one = 1'b1; tick(50);
    @(negedge clk);
    chk("hold_a_cnt", bus_a.bit_count, 1); chk("hold_c_cnt", bus_c.bit_count, 1);
    btn_one = 1'b0; tick(5);
    btn_one = 1'b1; btn_zero = 1'b1; tick(5);
    btn_one = 1'b0; btn_zero = 1'b0; tick(5);
    @(negedge clk);
    chk("both_a_cnt", bus_a.bit_count, 1); chk("both_b_cnt", bus_b.bit_count, 1);

    // Restart mid-word, then key 0,1,1,0
    press_bit(1'b0);
    @(negedge clk); chk("part_a_cnt", bus_a.bit_count, 2);
    press_start();
    @(negedge clk);
    chk("rst_a_cnt", bus_a.bit_count, 0); chk("rst_c_cnt", bus_c.bit_count, 0);
    q_a.push_back('{4'b0110, 1'b1, 1'b0});
    q_b.push_back('{4'b0110, 1'b1, 1'b0});
    q_c.push_back('{4'b0110, 1'b1, 1'b1});
    key4(4'b0110);
    @(negedge clk);
    chk("w3_a_busy", bus_a.busy, 0); chk("w3_c_ovr", bus_c.overrun, 1);

    // Partial word then asynchronous reset pulse
    press_start();
    press_bit(1'b1); press_bit(1'b0); press_bit(1'b1);
    @(negedge clk); chk("p3_a_cnt", bus_a.bit_count, 3); chk("p3_c_cnt", bus_c.bit_count, 3);
    tick(1);
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    chk_idle_all("arst");
    press_bit(1'b1);
    @(negedge clk);
    chk("post_a_cnt", bus_a.bit_count, 0); chk("post_c_cnt", bus_c.bit_count, 0);
    chk("post_a_busy", bus_a.busy, 0);

    tick(10);
    chk("a_pending", q_a.size(), 0);
    chk("b_pending", q_b.size(), 0);
    chk("c_pending", q_c.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_btn_serial_deserializer
`default_nettype wire

// File: doc/btn_serial_deserializer.md
Name: btn_serial_deserializer

Overview:
- Parametrised successor to the team's two-button serial entry block: the user keys a WIDTH-bit word one bit at a time ("one" and "zero" buttons) after an active-low start press.
- Adds input synchronisation, one bit per press (edge-detected), selectable bit order, single-word or continuous mode, a valid/ready output handshake and overrun detection.
- Sits between the board push-buttons and the VGA pattern/colour logic that consumes data_out.

Parameters:
- WIDTH, 4, bits per word (2..16).
- MSB_FIRST, 1, 1: first keyed bit ends in data_out[WIDTH-1]; 0: first keyed bit ends in data_out[0].
- CONTINUOUS, 0, 0: return to IDLE after each word; 1: stay in COLLECT and take the next word immediately.
- SYNC_STAGES, 2, flip-flop stages in each button synchroniser (>=2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start_n  in  1  start button, active low, asynchronous to clk.
- btn_one  in  1  enter '1' (active high, asynchronous).
- btn_zero  in  1  enter '0' (active high, asynchronous).
- out_ready  in  1  consumer accepts data_out.
- data_out  out  WIDTH  last completed word.
- out_valid  out  1  data_out holds an unconsumed word.
- word_done  out  1  one-cycle pulse on each word completion (accepted or dropped).
- bit_count  out  $clog2(WIDTH+1)  bits keyed into the current partial word.
- busy  out  1  high in COLLECT.
- overrun  out  1  sticky: a word completed while out_valid was high and out_ready low.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; data_out=0, out_valid=0, word_done=0, bit_count=0, busy=0, overrun=0; shift register and all synchroniser flops cleared. Reset asserted mid-word discards the partial word.
- Each input passes through SYNC_STAGES flops, then a registered previous-level flop. Press event = synced rises 0->1 (start: synced falls 1->0). With SYNC_STAGES=2, a press held from before posedge k is acted on at posedge k+2. A held button produces exactly one event.
- States: IDLE, COLLECT.
- IDLE: start event -> COLLECT; shift register=0, bit_count=0, overrun=0. Button events ignored.
- COLLECT: start event -> restart the word (shift register=0, bit_count=0); remain in COLLECT; overrun unchanged.
- COLLECT bit accept: exactly one of the btn_one/btn_zero events in a cycle. Events on both in the same cycle are ignored. When accepted, b=1 for btn_one and b=0 for btn_zero.
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], b}.
  - MSB_FIRST=0: sr <= {b, sr[WIDTH-1:1]}.
  - bit_count increments.
- Start event and bit event in the same cycle: start wins, and the bit is discarded.
- Completion: the accepted bit is bit WIDTH. At that same edge:
  - bit_count <= 0 and sr <= 0, and word_done pulses for 1 cycle.
  - If out_valid=0, or (out_valid=1 and out_ready=1): data_out <= completed word, out_valid <= 1.
  - Else the new word is dropped, data_out is unchanged, and overrun <= 1.
  - Next state is COLLECT if CONTINUOUS=1, else IDLE.
- Handshake: out_valid=1 and out_ready=1 at a posedge clears out_valid, unless a completion loads a new word at the same edge, in which case out_valid stays 1.
- data_out is stable while out_valid=1 unless a handshake occurs at that edge.
- busy = (state==COLLECT), registered.

Decomposition:
- Package btn_deser_pkg holds:
  - state enum {IDLE, COLLECT}.
  - count width function cnt_w(WIDTH) = $clog2(WIDTH+1).
- Sub-module btn_sync_edge (parameter SYNC_STAGES, POLARITY):
  - Contains the synchroniser and previous-level flop, and outputs a one-cycle event.
  - Instantiated three times: start_n (falling), btn_one and btn_zero (rising).

Test Plan:
- WIDTH=4, MSB_FIRST=1, out_ready=0:
  - start, then press 1,0,1,1 (each held 5 cycles, 5 cycles apart) -> data_out=4'b1011, out_valid=1, one word_done pulse, state IDLE, bit_count=0.
- Same sequence with MSB_FIRST=0 -> data_out=4'b1101.
- Hold btn_one high 50 cycles in COLLECT -> bit_count steps 0->1 exactly once. Raise btn_one and btn_zero on the same clock edge -> bit_count unchanged.
- CONTINUOUS=1, out_ready=0:
  - Key 1,1,1,1 -> data_out=4'hF, out_valid=1.
  - Then key 0,0,0,0 -> word_done pulses, data_out stays 4'hF, overrun=1.
  - Then pulse out_ready -> out_valid=0, overrun stays 1 until the next start from IDLE.
- Key 1,0 then a start press -> bit_count=0. Then key 0,1,1,0 -> data_out=4'b0110.
- Key 1,0,1, then pulse rst_n low for 1 cycle -> all outputs 0, state IDLE. A following btn_one press alone is ignored (bit_count=0).
